// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the read- and write-side FIFO controllers.
package fifo_pkg;

  function automatic int PTR_W(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB; zero-extended inputs convert correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module ptr_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_reg [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= d;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer/status controller of the dual-clock FIFO.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH:0]   w_gray_ptr,
  output logic [ADDR_WIDTH-1:0] r_address,
  output logic [ADDR_WIDTH:0]   r_ptr,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic [ADDR_WIDTH:0]   r_level,
  output logic                  r_underflow
);

  localparam int PW = PTR_W(ADDR_WIDTH);
  localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] level_next;
  logic          rd_fire;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (r_clk),
    .reset (reset),
    .d     (w_gray_ptr),
    .q     (wq_gray)
  );

  always_comb begin
    wq_bin     = PW'(gray2bin(32'(wq_gray)));
    rd_fire    = r_en & ~r_empty;
    bin_next   = r_bin + PW'(rd_fire);
    gray_next  = PW'(bin2gray(32'(bin_next)));
    level_next = wq_bin - bin_next;
  end

  // Flags are computed from the post-read pointer so a read is reflected on the same edge.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_level        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= bin_next;
      r_ptr          <= gray_next;
      r_level        <= level_next;
      r_empty        <= (gray_next == wq_gray);
      r_almost_empty <= (level_next <= AE_THRESH);
      r_underflow    <= r_underflow | (r_en & r_empty);
    end
  end

  assign r_address = r_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl (default parameters).
module tb_fifo_read_ctrl;

  logic       r_clk = 1'b0;
  logic       reset = 1'b1;
  logic       r_en = 1'b0;
  logic [5:0] w_gray_ptr = 6'b000011;
  logic [4:0] r_address;
  logic [5:0] r_ptr;
  logic       r_empty;
  logic       r_almost_empty;
  logic [5:0] r_level;
  logic       r_underflow;

  int total = 0;
  int bad = 0;

  fifo_read_ctrl #(
    .ADDR_WIDTH    (5),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (4)
  ) dut (
    .r_clk          (r_clk),
    .reset          (reset),
    .r_en           (r_en),
    .w_gray_ptr     (w_gray_ptr),
    .r_address      (r_address),
    .r_ptr          (r_ptr),
    .r_empty        (r_empty),
    .r_almost_empty (r_almost_empty),
    .r_level        (r_level),
    .r_underflow    (r_underflow)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  function automatic logic [5:0] g(input int b);
    logic [5:0] v;
    v = 6'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, int'(r_empty), 1);
    check({tag, "_aempty"}, int'(r_almost_empty), 1);
    check({tag, "_level"}, int'(r_level), 0);
    check({tag, "_ptr"}, int'(r_ptr), 0);
    check({tag, "_addr"}, int'(r_address), 0);
    check({tag, "_uflow"}, int'(r_underflow), 0);
  endtask

  int rb;
  int wb;
  int exp_rd;
  logic [5:0] prev_ptr;

  initial begin
    // Reset held while the write pointer is nonzero: synchroniser must stay cleared.
    #1;
    tick(); tick(); tick();
    check_reset_state("reset");
    $display("txn reset-hold level=%0d empty=%0d", r_level, r_empty);

    w_gray_ptr = 6'd0;
    tick();
    reset = 1'b0;
    tick();

    // Synchroniser latency: step Gray 1, 3, 2 (binary 1..3).
    w_gray_ptr = g(1); tick();
    check("sync_e1", int'(r_empty), 1);
    w_gray_ptr = g(2); tick();
    check("sync_e2", int'(r_empty), 1);
    w_gray_ptr = g(3); tick();
    check("sync_e3", int'(r_empty), 0);
    check("sync_l3", int'(r_level), 1);
    tick();
    check("sync_l4", int'(r_level), 2);
    tick();
    check("sync_l5", int'(r_level), 3);
    check("sync_ae", int'(r_almost_empty), 1);
    $display("txn sync level=%0d empty=%0d aempty=%0d", r_level, r_empty, r_almost_empty);

    // Drain: a fresh restart so the read pointer is 0 with write binary 10.
    reset = 1'b1; w_gray_ptr = g(10); #1;
    reset = 1'b0;
    tick(); tick(); tick();
    check("drain_l0", int'(r_level), 10);
    check("drain_ae0", int'(r_almost_empty), 0);
    r_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_rd = (i + 1 < 10) ? i + 1 : 10;
      check("drain_addr", int'(r_address), exp_rd);
      check("drain_level", int'(r_level), 10 - exp_rd);
      check("drain_empty", int'(r_empty), (exp_rd == 10) ? 1 : 0);
      check("drain_uflow", int'(r_underflow), (i >= 10) ? 1 : 0);
      $display("txn drain i=%0d addr=%0d level=%0d empty=%0d uflow=%0d",
               i, r_address, r_level, r_empty, r_underflow);
    end
    r_en = 1'b0;
    check("drain_ptr", int'(r_ptr), int'(g(10)));

    // Almost-empty boundary around level 4/5.
    w_gray_ptr = g(15);
    tick(); tick(); tick();
    check("ae_l5", int'(r_level), 5);
    check("ae_d5", int'(r_almost_empty), 0);
    r_en = 1'b1; tick(); r_en = 1'b0;
    check("ae_l4", int'(r_level), 4);
    check("ae_a4", int'(r_almost_empty), 1);
    w_gray_ptr = g(16);
    tick(); tick();
    check("ae_hold", int'(r_almost_empty), 1);
    tick();
    check("ae_l5b", int'(r_level), 5);
    check("ae_d5b", int'(r_almost_empty), 0);
    $display("txn aempty level=%0d aempty=%0d", r_level, r_almost_empty);

    // Wrap: read and write every cycle for 70 reads across the 63->0 boundary.
    rb = 11; wb = 16;
    prev_ptr = r_ptr;
    check("wrap_start", int'(r_ptr), int'(g(rb)));
    r_en = 1'b1;
    for (int i = 0; i < 70; i++) begin
      wb = (wb + 1) % 64;
      w_gray_ptr = g(wb);
      tick();
      rb = (rb + 1) % 64;
      check("wrap_ptr", int'(r_ptr), int'(g(rb)));
      check("wrap_1bit", $countones(r_ptr ^ prev_ptr), 1);
      check("wrap_noempty", int'(r_empty), 0);
      check("wrap_addr", int'(r_address), rb % 32);
      $display("txn wrap i=%0d rbin=%0d ptr=%b empty=%0d", i, rb, r_ptr, r_empty);
      prev_ptr = r_ptr;
    end
    r_en = 1'b0;
    tick(); tick(); tick();
    check("wrap_level", int'(r_level), 5);

    // Reset mid-stream at level 7 while a read is in progress.
    wb = (wb + 2) % 64;
    w_gray_ptr = g(wb);
    tick(); tick(); tick();
    check("mid_l7", int'(r_level), 7);
    r_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_reset_state("mid_rst");
    $display("txn midreset level=%0d addr=%0d", r_level, r_address);
    r_en = 1'b0;
    w_gray_ptr = 6'd0;
    tick();
    reset = 1'b0;
    w_gray_ptr = g(2);
    tick(); tick(); tick();
    check("restart_addr0", int'(r_address), 0);
    check("restart_level", int'(r_level), 2);
    r_en = 1'b1; tick(); r_en = 1'b0;
    check("restart_addr1", int'(r_address), 1);
    check("restart_ptr", int'(r_ptr), int'(g(1)));
    $display("txn restart addr=%0d ptr=%b", r_address, r_ptr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
